// File: rtl/ingress_forward_arbiter.sv
// Round-robin scheduler for the shared packet-buffer read path. It grants one ingress port at a
// time and holds the grant until frame_last, a link drop, or a no-data timeout.
module ingress_forward_arbiter #(
  parameter int NPORTS     = 15,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1024
)(
  input  logic              clk_ram_ctl,
  input  logic              rst,
  input  logic [NPORTS-1:0] port_link_up,
  input  logic [NPORTS-1:0] port_frame_rdy,
  input  logic              fwd_space_ok,
  input  logic              frame_valid,
  input  logic              frame_last,
  output logic [NPORTS-1:0] forward_en,
  output logic [3:0]        grant_port,
  output logic              busy,
  output logic              abort,
  output logic [31:0]       frames_done
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // With no gap configured, a finished grant goes straight back to arbitration.
  localparam logic [1:0]    S_END    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [TW-1:0]     timer;
  logic [3:0]        gap_cnt;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] rot;
  logic [3:0]        pick [0:NPORTS];
  logic              link_ok;

  assign req = port_frame_rdy & port_link_up;
  assign busy = (state != S_IDLE);

  // forward_en is one-hot on grant_port while ACTIVE, so this selects the granted port's link.
  assign link_ok = |(port_link_up & forward_en);

  // rot[k] is the request of port (grant_port+1+k) mod NPORTS; the lowest set k wins.
  assign rot = NPORTS'({req, req} >> ({1'b0, grant_port} + 5'd1));
  assign pick[NPORTS] = grant_port;

  for (genvar k = 0; k < NPORTS; k++) begin : g_pick
    logic [4:0] sum;
    assign sum = {1'b0, grant_port} + 5'(k + 1);
    assign pick[k] = rot[k] ? ((sum >= 5'(NPORTS)) ? 4'(sum - 5'(NPORTS)) : sum[3:0])
                            : pick[k+1];
  end

  always_ff @(posedge clk_ram_ctl or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      forward_en  <= '0;
      grant_port  <= 4'(NPORTS - 1);
      abort       <= 1'b0;
      frames_done <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req && fwd_space_ok) begin
            grant_port <= pick[0];
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          forward_en <= NPORTS'(1) << grant_port;
          timer      <= '0;
          state      <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (frame_valid && frame_last) begin
            forward_en  <= '0;
            frames_done <= frames_done + 32'd1;
            gap_cnt     <= '0;
            state       <= S_END;
          end else if (!link_ok || (!frame_valid && timer == TMO_LAST)) begin
            forward_en <= '0;
            abort      <= 1'b1;
            gap_cnt    <= '0;
            state      <= S_END;
          end else if (frame_valid) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ingress_forward_arbiter.sv
// Bench for ingress_forward_arbiter: vector table, directed multi-cycle sequences, and random
// traffic checked against a cycle-level reference model.
module tb_ingress_forward_arbiter;
  localparam int N   = 15;
  localparam int GAP = 1;
  localparam int TMO = 16;
  localparam logic [N-1:0] ALL = 15'h7fff;
  localparam logic [N-1:0] L4  = 15'h7fef;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  link = ALL;
  logic [N-1:0]  rdy = '0;
  logic          space = 1'b0, fv = 1'b0, fl = 1'b0;
  logic [N-1:0]  fe;
  logic [3:0]    gp;
  logic          busy, ab;
  logic [31:0]   done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ingress_forward_arbiter #(.NPORTS(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk_ram_ctl(clk), .rst(rst), .port_link_up(link), .port_frame_rdy(rdy),
    .fwd_space_ok(space), .frame_valid(fv), .frame_last(fl),
    .forward_en(fe), .grant_port(gp), .busy(busy), .abort(ab), .frames_done(done));

  typedef struct {
    logic [N-1:0] rdy, link;
    logic         sp, fv, fl;
    logic [N-1:0] fe;
    logic [3:0]   gp;
    logic         busy, ab;
    logic [31:0]  done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] l, input logic s,
                              input logic v, input logic t, input logic [N-1:0] e,
                              input logic [3:0] g, input logic b, input logic a,
                              input logic [31:0] d);
    vec_t x;
    x.rdy = r; x.link = l; x.sp = s; x.fv = v; x.fl = t;
    x.fe = e; x.gp = g; x.busy = b; x.ab = a; x.done = d;
    return x;
  endfunction

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic do_reset();
    rst = 1'b1; rdy = '0; link = ALL; space = 1'b0; fv = 1'b0; fl = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait (bounded) for a grant to become visible, then check it is the expected port.
  task automatic wait_grant(input string name, input int port);
    int n = 0;
    while (fe == '0 && n < 12) begin tick(); n++; end
    check({name, "_seen"}, 32'(fe != '0), 32'd1);
    check({name, "_port"}, 32'(gp), 32'(port));
    check({name, "_fe"}, 32'(fe), 32'(N'(1) << port));
  endtask

  // Stream a frame of nw words, then confirm the grant drops and the gap lasts GAP cycles.
  task automatic send_frame(input string name, input int nw);
    for (int w = 0; w < nw; w++) begin
      fv = 1'b1; fl = (w == nw - 1); tick();
    end
    fv = 1'b0; fl = 1'b0;
    check({name, "_drop"}, 32'(fe), 32'd0);
    check({name, "_gap"}, 32'(busy), 32'd1);
    tick();
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Reference model: who owns the buffer, how long it has been silent, cooldown left.
  int          m_ptr, m_cool, m_quiet;
  logic        m_on, m_wait, m_abort;
  logic [31:0] m_done;

  task automatic model_reset();
    m_ptr = N - 1; m_cool = 0; m_quiet = 0; m_on = 0; m_wait = 0; m_abort = 0; m_done = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic s,
                            input logic v, input logic t);
    logic [N-1:0] rq;
    rq = r & l;
    m_abort = 0;
    if (m_on) begin
      if (v && t) begin
        m_on = 0; m_done++; m_cool = GAP;
      end else if (!bit_at(l, m_ptr)) begin
        m_on = 0; m_abort = 1; m_cool = GAP;
      end else if (v) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet >= TMO) begin m_on = 0; m_abort = 1; m_cool = GAP; end
      end
    end else if (m_wait) begin
      m_wait = 0; m_on = 1; m_quiet = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (rq != '0 && s) begin
      for (int i = 1; i <= N; i++) begin
        int p;
        p = (m_ptr + i) % N;
        if (bit_at(rq, p)) begin m_ptr = p; m_wait = 1; break; end
      end
    end
  endtask

  vec_t tbl [23];

  initial begin
    tbl[0]  = mk(15'h0010, ALL, 1, 0, 0, 15'h0000, 4, 1, 0, 0);
    tbl[1]  = mk(15'h0010, ALL, 1, 0, 0, 15'h0010, 4, 1, 0, 0);
    tbl[2]  = mk(15'h0010, ALL, 1, 1, 0, 15'h0010, 4, 1, 0, 0);
    tbl[3]  = mk(15'h0010, ALL, 1, 1, 0, 15'h0010, 4, 1, 0, 0);
    tbl[4]  = mk(15'h0010, ALL, 1, 1, 0, 15'h0010, 4, 1, 0, 0);
    tbl[5]  = mk(15'h0010, ALL, 1, 1, 1, 15'h0000, 4, 1, 0, 1);
    tbl[6]  = mk(15'h0000, ALL, 1, 0, 0, 15'h0000, 4, 0, 0, 1);
    tbl[7]  = mk(15'h0000, ALL, 1, 1, 1, 15'h0000, 4, 0, 0, 1);
    tbl[8]  = mk(15'h0004, ALL, 0, 0, 0, 15'h0000, 4, 0, 0, 1);
    tbl[9]  = mk(15'h0004, ALL, 0, 0, 0, 15'h0000, 4, 0, 0, 1);
    tbl[10] = mk(15'h0004, ALL, 1, 0, 0, 15'h0000, 2, 1, 0, 1);
    tbl[11] = mk(15'h0004, ALL, 1, 0, 0, 15'h0004, 2, 1, 0, 1);
    tbl[12] = mk(15'h0004, ALL, 1, 1, 1, 15'h0000, 2, 1, 0, 2);
    tbl[13] = mk(15'h0000, ALL, 1, 0, 0, 15'h0000, 2, 0, 0, 2);
    tbl[14] = mk(15'h0010, ALL, 1, 0, 0, 15'h0000, 4, 1, 0, 2);
    tbl[15] = mk(15'h0010, ALL, 1, 0, 0, 15'h0010, 4, 1, 0, 2);
    tbl[16] = mk(15'h0010, L4,  1, 1, 1, 15'h0000, 4, 1, 0, 3);
    tbl[17] = mk(15'h0000, ALL, 1, 0, 0, 15'h0000, 4, 0, 0, 3);
    tbl[18] = mk(15'h0010, ALL, 1, 0, 0, 15'h0000, 4, 1, 0, 3);
    tbl[19] = mk(15'h0010, ALL, 1, 0, 0, 15'h0010, 4, 1, 0, 3);
    tbl[20] = mk(15'h0010, ALL, 1, 1, 0, 15'h0010, 4, 1, 0, 3);
    tbl[21] = mk(15'h0010, L4,  1, 1, 0, 15'h0000, 4, 1, 1, 3);
    tbl[22] = mk(15'h0000, ALL, 1, 0, 0, 15'h0000, 4, 0, 0, 3);

    // Reset values
    do_reset();
    check("rst_fe", 32'(fe), 32'd0);
    check("rst_gp", 32'(gp), 32'd14);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(ab), 32'd0);
    check("rst_done", done, 32'd0);

    // Vector table: single grant, ignored bus traffic, space gating, link drop vs frame_last
    for (int i = 0; i < 23; i++) begin
      rdy = tbl[i].rdy; link = tbl[i].link; space = tbl[i].sp; fv = tbl[i].fv; fl = tbl[i].fl;
      tick();
      check($sformatf("vec%0d_fe", i), 32'(fe), 32'(tbl[i].fe));
      check($sformatf("vec%0d_gp", i), 32'(gp), 32'(tbl[i].gp));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("vec%0d_abort", i), 32'(ab), 32'(tbl[i].ab));
      check($sformatf("vec%0d_done", i), done, tbl[i].done);
    end
    fv = 1'b0; fl = 1'b0; link = ALL;

    // Round-robin order with three steady requesters
    do_reset();
    rdy = 15'h0019; space = 1'b1;
    begin
      int order [6] = '{0, 3, 4, 0, 3, 4};
      for (int g = 0; g < 6; g++) begin
        wait_grant($sformatf("rr%0d", g), order[g]);
        send_frame($sformatf("rr%0d", g), 1 + g % 3);
      end
    end
    check("rr_done", done, 32'd6);

    // Timeout: port 3 granted, bus silent; abort once, pointer moves past port 3
    rdy = 15'h0008;
    wait_grant("tmo", 3);
    rdy = 15'h0029;
    begin
      int drop_k = -1, ab_k = -1, ab_n = 0;
      for (int k = 1; k <= TMO + 4; k++) begin
        tick();
        if (ab) begin ab_n++; ab_k = k; end
        if (fe == '0 && drop_k < 0) drop_k = k;
      end
      check("tmo_drop_cycle", 32'(drop_k), 32'(TMO));
      check("tmo_abort_cycle", 32'(ab_k), 32'(TMO));
      check("tmo_abort_count", 32'(ab_n), 32'd1);
      check("tmo_done", done, 32'd6);
    end
    wait_grant("tmo_next", 5);

    // Asynchronous reset during ACTIVE, then rotation restarts at port 0
    #2 rst = 1'b1;
    #1;
    check("arst_fe", 32'(fe), 32'd0);
    check("arst_gp", 32'(gp), 32'd14);
    check("arst_busy", 32'(busy), 32'd0);
    rdy = 15'h0021;
    tick();
    rst = 1'b0;
    wait_grant("arst_next", 0);
    send_frame("arst", 2);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r, l;
      logic s, v, t;
      r = N'($urandom) & N'($urandom);
      l = ALL;
      if ($urandom_range(0, 9) == 0) l = ~(N'(1) << $urandom_range(0, N - 1));
      s = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 2) != 0) && (c % 200 < 150);
      t = ($urandom_range(0, 3) == 0);
      rdy = r; link = l; space = s; fv = v; fl = t;
      tick();
      model_step(r, l, s, v, t);
      check($sformatf("rnd%0d_fe", c), 32'(fe), m_on ? 32'(N'(1) << m_ptr) : 32'd0);
      check($sformatf("rnd%0d_gp", c), 32'(gp), 32'(m_ptr));
      check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_on || m_wait || m_cool > 0));
      check($sformatf("rnd%0d_abort", c), 32'(ab), 32'(m_abort));
      check($sformatf("rnd%0d_done", c), done, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
